// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Single-outstanding-request instruction fetch stage with
//                stall hold and decode-stage redirect handling.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   StallF,
   input  logic                   PCSrcD,
   input  logic [ADDR_WIDTH-1:0]  PCBranchD,
   output logic                   ImemReq,
   output logic [ADDR_WIDTH-1:0]  ImemAddr,
   input  logic                   ImemRvalid,
   input  logic [INSTR_WIDTH-1:0] ImemRdata,
   output logic [INSTR_WIDTH-1:0] InstrF,
   output logic [ADDR_WIDTH-1:0]  PCPlus4F,
   output logic                   ValidF
);

   localparam logic [1:0] c_ISSUE = 2'd0;
   localparam logic [1:0] c_WAIT  = 2'd1;
   localparam logic [1:0] c_HOLD  = 2'd2;
   localparam logic [1:0] c_DROP  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] c_FOUR     = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] c_PC_RESET = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [ADDR_WIDTH-1:0]  r_pc;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic [ADDR_WIDTH-1:0]  r_pc4;
   logic                   r_valid;

   logic                   w_redirect;
   logic                   w_capture;
   logic                   w_consume;
   logic [ADDR_WIDTH-1:0]  w_pc_inc;
   logic [ADDR_WIDTH-1:0]  w_target;
   logic                   w_req;
   logic                   w_unused;

   // A stalled decode register cannot accept a redirect either, so the
   // redirect only takes effect when the stall is released.
   assign w_redirect = PCSrcD & ~StallF;
   assign w_capture  = (r_state == c_WAIT) & ImemRvalid & ~w_redirect;
   assign w_consume  = (r_state == c_HOLD) & ~StallF;
   assign w_pc_inc   = r_pc + c_FOUR;
   assign w_target   = {PCBranchD[ADDR_WIDTH-1:2], 2'b00};
   assign w_unused   = ^PCBranchD[1:0];

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= c_ISSUE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ISSUE: begin
            w_state_nxt = w_redirect ? c_DROP : c_WAIT;
         end
         c_WAIT: begin
            if (ImemRvalid) begin
               w_state_nxt = w_redirect ? c_ISSUE : c_HOLD;
            end else if (w_redirect) begin
               w_state_nxt = c_DROP;
            end
         end
         c_HOLD: begin
            if (!StallF) begin
               w_state_nxt = c_ISSUE;
            end
         end
         c_DROP: begin
            // The stale response must still be absorbed even if another
            // redirect arrives alongside it; otherwise DROP would never exit.
            if (ImemRvalid) begin
               w_state_nxt = c_ISSUE;
            end
         end
         default: begin
            w_state_nxt = c_ISSUE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      w_req = 1'b0;
      if ((r_state == c_ISSUE) && !RST) begin
         w_req = 1'b1;
      end
   end

   assign ImemReq  = w_req;
   assign ImemAddr = r_pc;

   // Datapath: PC and the instruction presented to decode
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pc    <= c_PC_RESET;
         r_instr <= '0;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_redirect) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
         end else if (w_consume) begin
            r_pc    <= w_pc_inc;
            r_valid <= 1'b0;
         end else if (w_capture) begin
            r_instr <= ImemRdata;
            r_pc4   <= w_pc_inc;
            r_valid <= 1'b1;
         end
      end
   end

   assign InstrF   = r_instr;
   assign PCPlus4F = r_pc4;
   assign ValidF   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage with a latency-programmable
//                memory model and an expected-instruction scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        StallF = 1'b0;
   logic        PCSrcD = 1'b0;
   logic [31:0] PCBranchD = '0;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemRvalid = 1'b0;
   logic [31:0] ImemRdata = '0;
   logic [31:0] InstrF;
   logic [31:0] PCPlus4F;
   logic        ValidF;

   always #5 CLK = ~CLK;

   fetch_stage #(
      .ADDR_WIDTH  (32),
      .INSTR_WIDTH (32),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .StallF     (StallF),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .ImemReq    (ImemReq),
      .ImemAddr   (ImemAddr),
      .ImemRvalid (ImemRvalid),
      .ImemRdata  (ImemRdata),
      .InstrF     (InstrF),
      .PCPlus4F   (PCPlus4F),
      .ValidF     (ValidF)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0) return 32'h2002_0005;
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t sbq[$];

   task automatic push(input logic [31:0] i, input logic [31:0] p);
      exp_t e;
      e.instr = i;
      e.pc4   = p;
      sbq.push_back(e);
   endtask

   // Stimulus applied for the coming cycle
   logic        drv_rst    = 1'b1;
   logic        drv_stall  = 1'b0;
   logic        drv_redir  = 1'b0;
   logic        drv_inj    = 1'b0;
   logic [31:0] drv_target = '0;

   // Memory model state
   int          lat   = 1;
   bit          pend  = 1'b0;
   int          cnt   = 0;
   logic [31:0] paddr = '0;
   logic        prev_valid = 1'b0;

   // One clock cycle: drive just after the rising edge, sample at the falling edge.
   task automatic tick();
      exp_t e;
      @(posedge CLK);
      #1;
      RST        = drv_rst;
      StallF     = drv_stall;
      PCSrcD     = drv_redir;
      PCBranchD  = drv_target;
      ImemRvalid = 1'b0;
      ImemRdata  = '0;
      if (pend) begin
         cnt--;
         if (cnt <= 0) begin
            pend       = 1'b0;
            ImemRvalid = 1'b1;
            ImemRdata  = memf(paddr);
         end
      end
      if (drv_inj) begin
         ImemRvalid = 1'b1;
         ImemRdata  = 32'hDEAD_BEEF;
      end
      @(negedge CLK);
      if (ImemReq) begin
         pend  = 1'b1;
         cnt   = lat;
         paddr = ImemAddr;
      end
      if (ValidF && !prev_valid) begin
         chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_instr", InstrF, e.instr);
            chk("sb_pc4", PCPlus4F, e.pc4);
         end
      end
      prev_valid = ValidF;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_valid", 32'(ValidF), 32'd0);
      chk("rst_instr", InstrF, 32'h0);
      chk("rst_pc4", PCPlus4F, 32'h0);
      chk("rst_req", 32'(ImemReq), 32'd0);
      chk("rst_addr", ImemAddr, 32'h0);

      // Basic fetch with 1-cycle memory
      drv_rst = 1'b0;
      push(memf(32'h0), 32'h4);
      tick();
      chk("c1_req", 32'(ImemReq), 32'd1);
      chk("c1_addr", ImemAddr, 32'h0);
      tick();
      chk("c2_req", 32'(ImemReq), 32'd0);
      chk("c2_valid", 32'(ValidF), 32'd0);
      tick();
      chk("c3_valid", 32'(ValidF), 32'd1);
      chk("c3_instr", InstrF, 32'h2002_0005);
      chk("c3_pc4", PCPlus4F, 32'h4);
      push(memf(32'h4), 32'h8);
      tick();
      chk("c4_req", 32'(ImemReq), 32'd1);
      chk("c4_addr", ImemAddr, 32'h4);
      tick();

      // Five stalled HOLD cycles
      drv_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_req", 32'(ImemReq), 32'd0);
         chk("stall_valid", 32'(ValidF), 32'd1);
         chk("stall_instr", InstrF, memf(32'h4));
         chk("stall_pc4", PCPlus4F, 32'h8);
      end
      drv_stall = 1'b0;
      tick();
      chk("unstall_valid", 32'(ValidF), 32'd1);
      lat = 5;
      tick();
      chk("c12_req", 32'(ImemReq), 32'd1);
      chk("c12_addr", ImemAddr, 32'h8);
      tick();

      // Redirect while waiting; the late response must be dropped
      drv_redir  = 1'b1;
      drv_target = 32'h0000_0100;
      tick();
      chk("c14_valid", 32'(ValidF), 32'd0);
      drv_redir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("drop_req", 32'(ImemReq), 32'd0);
         chk("drop_valid", 32'(ValidF), 32'd0);
      end
      lat = 1;
      push(memf(32'h100), 32'h104);
      tick();
      chk("redir_req", 32'(ImemReq), 32'd1);
      chk("redir_addr", ImemAddr, 32'h100);
      tick();
      tick();
      chk("c20_valid", 32'(ValidF), 32'd1);
      tick();
      chk("c21_addr", ImemAddr, 32'h104);

      // Redirect in the same cycle as the response
      drv_redir  = 1'b1;
      drv_target = 32'h0000_0200;
      tick();
      drv_redir = 1'b0;
      tick();
      chk("c23_req", 32'(ImemReq), 32'd1);
      chk("c23_addr", ImemAddr, 32'h200);
      chk("c23_valid", 32'(ValidF), 32'd0);
      chk("c23_instr", InstrF, memf(32'h100));
      push(memf(32'h200), 32'h204);
      tick();

      // Redirect from HOLD to a misaligned target
      drv_redir  = 1'b1;
      drv_target = 32'h0000_0103;
      tick();
      drv_redir = 1'b0;
      push(memf(32'h100), 32'h104);
      tick();
      chk("mask_req", 32'(ImemReq), 32'd1);
      chk("mask_addr", ImemAddr, 32'h100);
      chk("c26_valid", 32'(ValidF), 32'd0);
      tick();

      // Address wrap at the top of memory
      drv_redir  = 1'b1;
      drv_target = 32'hFFFF_FFFC;
      tick();
      drv_redir = 1'b0;
      push(memf(32'hFFFF_FFFC), 32'h0);
      tick();
      chk("wrap_addr", ImemAddr, 32'hFFFF_FFFC);
      tick();
      tick();
      chk("wrap_pc4", PCPlus4F, 32'h0);

      // Redirect while issuing
      drv_redir  = 1'b1;
      drv_target = 32'h0000_0300;
      tick();
      chk("wrap_next_req", 32'(ImemReq), 32'd1);
      chk("wrap_next_addr", ImemAddr, 32'h0);
      drv_redir = 1'b0;
      tick();
      chk("c33_req", 32'(ImemReq), 32'd0);
      chk("c33_valid", 32'(ValidF), 32'd0);
      push(memf(32'h300), 32'h304);
      tick();
      chk("c34_addr", ImemAddr, 32'h300);
      tick();

      // Spurious response in HOLD and in ISSUE
      drv_stall = 1'b1;
      drv_inj   = 1'b1;
      tick();
      drv_inj = 1'b0;
      tick();
      chk("inj_hold_instr", InstrF, memf(32'h300));
      chk("inj_hold_valid", 32'(ValidF), 32'd1);
      chk("inj_hold_req", 32'(ImemReq), 32'd0);
      drv_stall = 1'b0;
      tick();
      drv_inj = 1'b1;
      push(memf(32'h304), 32'h308);
      tick();
      chk("c39_addr", ImemAddr, 32'h304);
      drv_inj = 1'b0;
      tick();
      chk("c40_valid", 32'(ValidF), 32'd0);
      tick();
      chk("c41_instr", InstrF, memf(32'h304));

      // Asynchronous reset during WAIT with a late response afterwards
      lat = 3;
      tick();
      chk("c42_addr", ImemAddr, 32'h308);
      tick();
      #2;
      RST     = 1'b1;
      drv_rst = 1'b1;
      #1;
      chk("arst_valid", 32'(ValidF), 32'd0);
      chk("arst_instr", InstrF, 32'h0);
      chk("arst_pc4", PCPlus4F, 32'h0);
      chk("arst_req", 32'(ImemReq), 32'd0);
      chk("arst_addr", ImemAddr, 32'h0);
      tick();
      drv_rst = 1'b0;
      lat     = 1;
      tick();
      chk("post_rst_req", 32'(ImemReq), 32'd1);
      chk("post_rst_addr", ImemAddr, 32'h0);
      push(memf(32'h0), 32'h4);
      tick();
      chk("c46_valid", 32'(ValidF), 32'd0);
      tick();
      chk("c47_instr", InstrF, 32'h2002_0005);
      tick();
      tick();
      chk("sb_left", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, PC and memory address width.
REQ-002 Parameter: INSTR_WIDTH, 32, instruction width.
REQ-003 Parameter: RESET_PC, 32'h0000_0000, first fetch address; bits [1:0] zero.
REQ-004 CLK  in  1  single clock; all state on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 StallF  in  1  1 = downstream decode register not accepting; hold presented instruction.
REQ-007 PCSrcD  in  1  1 = taken branch/jump redirect from decode.
REQ-008 PCBranchD  in  ADDR_WIDTH  redirect target.
REQ-009 ImemReq  out  1  one-cycle request pulse to instruction memory.
REQ-010 ImemAddr  out  ADDR_WIDTH  request address, valid while ImemReq=1.
REQ-011 ImemRvalid  in  1  read data valid, earliest one cycle after ImemReq.
REQ-012 ImemRdata  in  INSTR_WIDTH  read data.
REQ-013 InstrF  out  INSTR_WIDTH  fetched instruction presented to decode register.
REQ-014 PCPlus4F  out  ADDR_WIDTH  address of InstrF plus 4.
REQ-015 ValidF  out  1  1 = InstrF/PCPlus4F hold a real instruction; 0 = bubble (drives decode-register clear).

Function
REQ-016 The block SHALL be a registered FSM with states ISSUE, WAIT, HOLD, DROP and at most one outstanding memory request.
REQ-017 ISSUE: ImemReq=1, ImemAddr=PC for exactly that cycle; next state WAIT.
REQ-018 WAIT: on ImemRvalid=1 capture InstrF<=ImemRdata, PCPlus4F<=PC+4 (mod 2^ADDR_WIDTH), ValidF<=1; next HOLD; else remain WAIT.
REQ-019 HOLD with StallF=0, PCSrcD=0: instruction consumed at this edge; PC<=PC+4, ValidF<=0, next ISSUE.
REQ-020 HOLD with StallF=1: InstrF, PCPlus4F, ValidF, PC unchanged; remain HOLD; PCSrcD ignored.
REQ-021 Redirect (PCSrcD=1, StallF=0) SHALL load PC<={PCBranchD[ADDR_WIDTH-1:2],2'b00} and ValidF<=0.
REQ-022 Redirect next state: from ISSUE -> DROP; from WAIT without ImemRvalid -> DROP; from WAIT with ImemRvalid same cycle -> ISSUE (data discarded, not captured); from HOLD -> ISSUE; from DROP -> DROP.
REQ-023 DROP: ImemReq=0; on ImemRvalid=1 discard data, next ISSUE; outputs InstrF/PCPlus4F unchanged, ValidF=0.
REQ-024 StallF=1 in ISSUE/WAIT/DROP SHALL NOT block request issue or response capture.
REQ-025 ImemRvalid in ISSUE or HOLD is a protocol violation and SHALL be ignored without state change.
REQ-026 ImemAddr[1:0] SHALL always be 2'b00; ImemAddr=PC when ImemReq=0.
REQ-027 Best-case throughput: one instruction per 3 cycles with 1-cycle memory latency.

Reset
REQ-028 While RST=1: PC=RESET_PC, state=ISSUE, InstrF=0, PCPlus4F=0, ValidF=0, ImemReq=0.
REQ-029 First ImemReq SHALL assert in the first cycle after RST deasserts.
REQ-030 RST asserted mid-request SHALL abandon the outstanding request; a late ImemRvalid after reset release (in ISSUE) SHALL be ignored per REQ-025.

Verification
REQ-031 Reset release, 1-cycle memory returning 32'h2002_0005 at 0x0 -> ImemReq at cycle 1 with addr 0x0; cycle 3 ValidF=1, InstrF=32'h2002_0005, PCPlus4F=0x4; next ImemAddr=0x4.
REQ-032 StallF=1 for 5 cycles during HOLD -> InstrF/PCPlus4F/ValidF constant, no ImemReq; first request to PC+4 one cycle after StallF falls.
REQ-033 PCSrcD=1, PCBranchD=0x0000_0100 while WAIT, memory responds 3 cycles later -> response discarded, ValidF stays 0, next ImemReq addr 0x100.
REQ-034 PCSrcD=1 in same cycle as ImemRvalid in WAIT -> data not captured, ImemReq to target next cycle.
REQ-035 PC=0xFFFF_FFFC fetch -> PCPlus4F=0x0000_0000, next ImemAddr=0x0.
REQ-036 PCBranchD=0x0000_0103 -> ImemAddr=0x0000_0100; RST pulse during WAIT -> all outputs 0, PC=RESET_PC asynchronously.
